// File: rtl/mod60_down_timer.sv
// Loadable two-digit cascaded down-counter (units mod A_MOD, tens mod B_MOD) with a borrow pulse.
// Optional build macro DOWN_TIMER_HOLD_AT_ZERO_EN: saturate at 00 and pulse Bo when 00 is first reached.
module mod60_down_timer #(
  parameter int A_W   = 4,
  parameter int B_W   = 3,
  parameter int A_MOD = 10,
  parameter int B_MOD = 6
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           load,
  input  logic           en,
  input  logic [A_W-1:0] Da,
  input  logic [B_W-1:0] Db,
  output logic [A_W-1:0] qa,
  output logic [B_W-1:0] qb,
  output logic           Bo,
  output logic           zero
);

  localparam logic [A_W-1:0] A_ZERO = {A_W{1'b0}};
  localparam logic [B_W-1:0] B_ZERO = {B_W{1'b0}};
  localparam logic [A_W-1:0] A_ONE  = A_W'(1);
  localparam logic [B_W-1:0] B_ONE  = B_W'(1);
  localparam logic [A_W-1:0] A_MAX  = A_W'(A_MOD - 1);
  localparam logic [B_W-1:0] B_MAX  = B_W'(B_MOD - 1);

  logic [A_W-1:0] qa_r;
  logic [B_W-1:0] qb_r;
  logic           bo_r;
  logic [A_W-1:0] qa_nxt_s;
  logic [B_W-1:0] qb_nxt_s;
  logic           bo_nxt_s;
  logic           lands_zero_s;

  function automatic logic [A_W-1:0] clamp_a(input logic [A_W-1:0] v);
    if (v > A_MAX) begin
      return A_MAX;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [B_W-1:0] clamp_b(input logic [B_W-1:0] v);
    if (v > B_MAX) begin
      return B_MAX;
    end else begin
      return v;
    end
  endfunction

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    qa_nxt_s     = qa_r;
    qb_nxt_s     = qb_r;
    bo_nxt_s     = 1'b0;
    lands_zero_s = 1'b0;
    case ({load, en})
      2'b10, 2'b11: begin
        qa_nxt_s = clamp_a(Da);
        qb_nxt_s = clamp_b(Db);
      end
      2'b01: begin
        if (qa_r != A_ZERO) begin
          qa_nxt_s     = qa_r - A_ONE;
          lands_zero_s = (qa_r == A_ONE) && (qb_r == B_ZERO);
        end else if (qb_r != B_ZERO) begin
          qa_nxt_s     = A_MAX;
          qb_nxt_s     = qb_r - B_ONE;
          lands_zero_s = (A_MAX == A_ZERO) && (qb_r == B_ONE);
        end else begin
`ifdef DOWN_TIMER_HOLD_AT_ZERO_EN
          // Saturated at 00: stay put, no further borrow.
          qa_nxt_s = A_ZERO;
          qb_nxt_s = B_ZERO;
          bo_nxt_s = 1'b0;
`else
          qa_nxt_s = A_MAX;
          qb_nxt_s = B_MAX;
          bo_nxt_s = 1'b1;
`endif
        end
`ifdef DOWN_TIMER_HOLD_AT_ZERO_EN
        if (lands_zero_s) begin
          bo_nxt_s = 1'b1;
        end else begin
          bo_nxt_s = bo_nxt_s;
        end
`endif
      end
      default: begin
        qa_nxt_s = qa_r;
        qb_nxt_s = qb_r;
      end
    endcase
  end

  // Digit and borrow registers; clr clears them immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qa_r <= A_ZERO;
      qb_r <= B_ZERO;
      bo_r <= 1'b0;
    end else begin
      qa_r <= qa_nxt_s;
      qb_r <= qb_nxt_s;
      bo_r <= bo_nxt_s;
    end
  end

  assign qa   = qa_r;
  assign qb   = qb_r;
  assign Bo   = bo_r;
  assign zero = (qa_r == A_ZERO) && (qb_r == B_ZERO);

endmodule

// File: tb/tb_mod60_down_timer.sv
// Self-checking bench for mod60_down_timer: vector table plus hand sequences for async clear.
module tb_mod60_down_timer;

`ifdef DOWN_TIMER_HOLD_AT_ZERO_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic       ld;
    logic       en;
    logic [3:0] da;
    logic [2:0] db;
    logic [3:0] qa;
    logic [2:0] qb;
    logic       bo;
    logic       z;
  } vec_t;

  typedef struct {
    logic [3:0] qa;
    logic [2:0] qb;
    logic       bo;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr, load, en;
  logic [3:0] Da;
  logic [2:0] Db;
  logic [3:0] qa;
  logic [2:0] qb;
  logic       Bo, zero;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  mod60_down_timer dut (
    .clk(clk), .clr(clr), .load(load), .en(en), .Da(Da), .Db(Db),
    .qa(qa), .qb(qb), .Bo(Bo), .zero(zero)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t r);
    chk({nm, ".qa"},   {4'd0, qa},   {4'd0, r.qa});
    chk({nm, ".qb"},   {5'd0, qb},   {5'd0, r.qb});
    chk({nm, ".Bo"},   {7'd0, Bo},   {7'd0, r.bo});
    chk({nm, ".zero"}, {7'd0, zero}, {7'd0, r.z});
  endtask

  task automatic step(input string nm, input logic c, input logic ld, input logic e,
                      input logic [3:0] da, input logic [2:0] db,
                      input logic [3:0] eqa, input logic [2:0] eqb,
                      input logic ebo, input logic ez);
    exp_t r;
    @(negedge clk);
    clr = c; load = ld; en = e; Da = da; Db = db;
    exp_q.push_back('{qa: eqa, qb: eqb, bo: ebo, z: ez});
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    chk_all(nm, r);
  endtask

  function automatic vec_t mk(input logic ld, input logic e, input logic [3:0] da,
                              input logic [2:0] db, input logic [3:0] eqa,
                              input logic [2:0] eqb, input logic ebo, input logic ez);
    vec_t v;
    v.ld = ld; v.en = e; v.da = da; v.db = db;
    v.qa = eqa; v.qb = eqb; v.bo = ebo; v.z = ez;
    return v;
  endfunction

  initial begin
    exp_t r;
    clr = 1'b1; load = 1'b0; en = 1'b0; Da = 4'd0; Db = 3'd0;
    #30;
    r = '{qa: 4'd0, qb: 3'd0, bo: 1'b0, z: 1'b1};
    chk_all("reset", r);
    step("rst_hold", 1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1);

    // load 57, count 8 down to 49
    vecs.push_back(mk(1'b1, 1'b0, 4'd7, 3'd5, 4'd7, 3'd5, 1'b0, 1'b0));
    for (int k = 6; k >= 0; k--)
      vecs.push_back(mk(1'b0, 1'b1, 4'd0, 3'd0, 4'(k), 3'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd9, 3'd4, 1'b0, 1'b0));
    // hold then resume
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 3'd0, 4'd9, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 3'd0, 4'd9, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd8, 3'd4, 1'b0, 1'b0));
    // underflow at 00
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1));
    vecs.push_back(HOLD ? mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1)
                        : mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd9, 3'd5, 1'b1, 1'b0));
    vecs.push_back(HOLD ? mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1)
                        : mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd8, 3'd5, 1'b0, 1'b0));
    // clamped load, then load+en together
    vecs.push_back(mk(1'b1, 1'b0, 4'd12, 3'd7, 4'd9, 3'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'd3, 3'd2, 4'd3, 3'd2, 1'b0, 1'b0));
    // 01 -> 00 -> next
    vecs.push_back(mk(1'b1, 1'b0, 4'd1, 3'd0, 4'd1, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3'd0, HOLD, 1'b1));
    vecs.push_back(HOLD ? mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1)
                        : mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd9, 3'd5, 1'b1, 1'b0));
    // load right after a borrow clears Bo
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1));
    // tens borrow from 10
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 3'd1, 4'd0, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd0, 3'd0, 4'd9, 3'd0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), 1'b0, vecs[i].ld, vecs[i].en, vecs[i].da, vecs[i].db,
           vecs[i].qa, vecs[i].qb, vecs[i].bo, vecs[i].z);

    // async clear between edges while Bo is high
    step("pre_load", 1'b0, 1'b1, 1'b0, HOLD ? 4'd1 : 4'd0, 3'd0,
         HOLD ? 4'd1 : 4'd0, 3'd0, 1'b0, !HOLD);
    step("pre_bo", 1'b0, 1'b0, 1'b1, 4'd0, 3'd0,
         HOLD ? 4'd0 : 4'd9, HOLD ? 3'd0 : 3'd5, 1'b1, HOLD);
    #20;
    clr = 1'b1;
    #1;
    r = '{qa: 4'd0, qb: 3'd0, bo: 1'b0, z: 1'b1};
    chk_all("clr_async", r);
    step("clr_held", 1'b1, 1'b1, 1'b1, 4'd5, 3'd3, 4'd0, 3'd0, 1'b0, 1'b1);

    // clear mid-count, then resume from 00
    step("mid_load", 1'b0, 1'b1, 1'b0, 4'd5, 3'd3, 4'd5, 3'd3, 1'b0, 1'b0);
    step("mid_dec", 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 4'd4, 3'd3, 1'b0, 1'b0);
    #20;
    clr = 1'b1;
    #1;
    chk_all("clr_mid", r);
    step("post_clr", 1'b0, 1'b0, 1'b1, 4'd0, 3'd0,
         HOLD ? 4'd0 : 4'd9, HOLD ? 3'd0 : 3'd5, !HOLD, HOLD);
    step("post_clr2", 1'b0, 1'b0, 1'b1, 4'd0, 3'd0,
         HOLD ? 4'd0 : 4'd8, HOLD ? 3'd0 : 3'd5, 1'b0, HOLD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
